// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: FSM states, error codes
// and geometry helpers derived from the word width and depth.
package dmem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_MISALIGNED = 2'd1;
  localparam logic [1:0] ERR_RANGE      = 2'd2;

  function automatic int unsigned bytes_f(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned lsb_f(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned idx_f(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_WIDTH word storage: one synchronous lane-masked write port and
// one synchronous read port sharing the address (read returns pre-write data).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic                             re,
  input  logic [idx_f(DEPTH)-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [bytes_f(DATA_WIDTH)-1:0]   be,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int unsigned BYTES = bytes_f(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
    for (int i = 0; i < BYTES; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed request/response data memory with per-byte store lanes,
// a post-reset zeroing sweep and alignment/range error reporting.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic                           reqWrite,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [DATA_WIDTH-1:0]          dataIn,
  input  logic [DATA_WIDTH/8-1:0]        byteEnable,
  output logic                           respValid,
  output logic [DATA_WIDTH-1:0]          dataOut,
  output logic                           error
);

  localparam int unsigned BYTES = bytes_f(DATA_WIDTH);
  localparam int unsigned LSB   = lsb_f(DATA_WIDTH);
  localparam int unsigned IDX   = idx_f(DEPTH);

  state_e                state_q, state_d;
  logic [IDX-1:0]        cnt_q, cnt_d;
  logic                  accept_c;
  logic [1:0]            err_code_c;
  logic [IDX-1:0]        idx_c;

  logic                  mem_we, mem_re;
  logic [IDX-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BYTES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_zero_q, rsp_store_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [BYTES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] merged_c;

  assign accept_c = reqValid && reqReady;
  assign idx_c    = address[LSB+IDX-1:LSB];

  // Misalignment takes priority over range when both apply.
  always_comb begin
    err_code_c = ERR_NONE;
    if (address[LSB-1:0] != '0) begin
      err_code_c = ERR_MISALIGNED;
    end else if (address[ADDR_WIDTH-1:LSB+IDX] != '0) begin
      err_code_c = ERR_RANGE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      reqReady    <= 1'b0;
      respValid   <= 1'b0;
      rsp_zero_q  <= 1'b1;
      rsp_store_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
      be_q        <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reqReady  <= (state_d == READY);
      respValid <= accept_c;
      if (accept_c) begin
        rsp_zero_q  <= (err_code_c != ERR_NONE);
        rsp_err_q   <= (err_code_c != ERR_NONE);
        rsp_store_q <= reqWrite;
        wd_q        <= dataIn;
        be_q        <= byteEnable;
      end
    end
  end

  // Next state and memory port control; reset suppresses every array access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = idx_c;
    mem_wdata = dataIn;
    mem_be    = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + IDX'(1);
        if (cnt_q == IDX'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (accept_c && (err_code_c == ERR_NONE)) begin
          mem_re = 1'b1;
          if (reqWrite) begin
            mem_we = 1'b1;
            mem_be = byteEnable;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    if (!resetN) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .rdata (mem_rdata)
  );

  // Store responses rebuild the merged word from the pre-write read and held store data.
  always_comb begin
    merged_c = mem_rdata;
    for (int i = 0; i < BYTES; i++) begin
      if (rsp_store_q && be_q[i]) begin
        merged_c[8*i +: 8] = wd_q[8*i +: 8];
      end
    end
    dataOut = rsp_zero_q ? '0 : merged_c;
  end

  assign error = rsp_err_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed self-checking bench for data_memory_be (DEPTH=16, DATA_WIDTH=32).
module tb_data_memory_be;

  logic        clk;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [3:0]  byteEnable;
  logic        respValid;
  logic [31:0] dataOut;
  logic        error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  data_memory_be #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (16)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWrite   (reqWrite),
    .address    (address),
    .dataIn     (dataIn),
    .byteEnable (byteEnable),
    .respValid  (respValid),
    .dataOut    (dataOut),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts negedge samples with reqReady low, starting at the current negedge.
  task automatic count_sweep(output int n);
    n = 0;
    while (!reqReady && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issues one request at a negedge and samples the response one cycle later.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic v, output logic [31:0] q,
                     output logic e);
    reqValid   = 1'b1;
    reqWrite   = w;
    address    = a;
    dataIn     = d;
    byteEnable = be;
    @(posedge clk);
    @(negedge clk);
    v = respValid;
    q = dataOut;
    e = error;
    reqValid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic v, e;
    logic [31:0] q;
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({reqReady, respValid, error} !== 3'b000 || dataOut !== 32'h0)
      $display("FAIL reset_outputs got rdy=%b rv=%b err=%b do=%h exp 0/0/0/0",
               reqReady, respValid, error, dataOut);
    else pass_cnt++;
    resetN = 1'b1;
    count_sweep(n);
    total_cnt++;
    if (n !== 16) $display("FAIL sweep_len got %0d exp 16", n);
    else pass_cnt++;
    req(1'b0, 32'h3C, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'h0)
      $display("FAIL load_3c got v=%b e=%b do=%h exp v=1 e=0 do=0", v, e, q);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic v, e;
    logic [31:0] q;
    req(1'b1, 32'h0, 32'd42, 4'hF, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'd42)
      $display("FAIL store42_resp got v=%b e=%b do=%h exp 1/0/%h", v, e, q, 32'd42);
    else pass_cnt++;
    req(1'b1, 32'h4, 32'd48, 4'hF, v, q, e);
    req(1'b0, 32'h0, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'd42)
      $display("FAIL load0 got v=%b e=%b do=%h exp 1/0/%h", v, e, q, 32'd42);
    else pass_cnt++;
    req(1'b0, 32'h4, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'd48)
      $display("FAIL load4 got v=%b e=%b do=%h exp 1/0/%h", v, e, q, 32'd48);
    else pass_cnt++;
    req(1'b1, 32'h0, 32'd48, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'd42)
      $display("FAIL be0_store_resp got v=%b e=%b do=%h exp 1/0/%h", v, e, q, 32'd42);
    else pass_cnt++;
    req(1'b0, 32'h0, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if (q !== 32'd42) $display("FAIL be0_load got %h exp %h", q, 32'd42);
    else pass_cnt++;
  endtask

  task automatic test_lanes();
    logic v, e;
    logic [31:0] q;
    req(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, v, q, e);
    req(1'b1, 32'h8, 32'h11223344, 4'b0101, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'hAA22CC44)
      $display("FAIL lane_store_resp got v=%b e=%b do=%h exp 1/0/aa22cc44", v, e, q);
    else pass_cnt++;
    req(1'b0, 32'h8, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if (q !== 32'hAA22CC44) $display("FAIL lane_load got %h exp aa22cc44", q);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic v, e;
    logic [31:0] q;
    req(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b11 || q !== 32'h0)
      $display("FAIL misaligned got v=%b e=%b do=%h exp 1/1/0", v, e, q);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({respValid, error} !== 2'b01 || dataOut !== 32'h0)
      $display("FAIL err_hold got v=%b e=%b do=%h exp 0/1/0", respValid, error, dataOut);
    else pass_cnt++;
    req(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b11 || q !== 32'h0)
      $display("FAIL out_of_range got v=%b e=%b do=%h exp 1/1/0", v, e, q);
    else pass_cnt++;
    req(1'b0, 32'h0, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'd42)
      $display("FAIL err_load0 got v=%b e=%b do=%h exp 1/0/%h", v, e, q, 32'd42);
    else pass_cnt++;
    req(1'b0, 32'h0, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if (q !== 32'd42) $display("FAIL err_load0_again got %h exp %h", q, 32'd42);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    address    = 32'hC;
    dataIn     = 32'h5;
    byteEnable = 4'hF;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({respValid, error} !== 2'b10 || dataOut !== 32'h5)
      $display("FAIL b2b_store got v=%b e=%b do=%h exp 1/0/5", respValid, error, dataOut);
    else pass_cnt++;
    reqWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    total_cnt++;
    if ({respValid, error} !== 2'b10 || dataOut !== 32'h5)
      $display("FAIL b2b_load got v=%b e=%b do=%h exp 1/0/5", respValid, error, dataOut);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (respValid !== 1'b0 || dataOut !== 32'h5)
      $display("FAIL b2b_hold got v=%b do=%h exp 0/5", respValid, dataOut);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic v, e;
    logic [31:0] q;
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    repeat (7) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (reqReady !== 1'b0) $display("FAIL midsweep_rdy got %b exp 0", reqReady);
    else pass_cnt++;
    resetN = 1'b1;
    count_sweep(n);
    total_cnt++;
    if (n !== 16) $display("FAIL midsweep_len got %0d exp 16", n);
    else pass_cnt++;
    req(1'b0, 32'h8, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'h0)
      $display("FAIL resweep_clear got v=%b e=%b do=%h exp 1/0/0", v, e, q);
    else pass_cnt++;
    // Reset in READY while a store is presented.
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    address    = 32'h0;
    dataIn     = 32'hDEADBEEF;
    byteEnable = 4'hF;
    resetN     = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({respValid, reqReady} !== 2'b00 || dataOut !== 32'h0)
      $display("FAIL ready_reset got v=%b rdy=%b do=%h exp 0/0/0", respValid, reqReady, dataOut);
    else pass_cnt++;
    reqValid = 1'b0;
    resetN   = 1'b1;
    count_sweep(n);
    total_cnt++;
    if (n !== 16) $display("FAIL ready_reset_len got %0d exp 16", n);
    else pass_cnt++;
    req(1'b0, 32'h0, 32'h0, 4'h0, v, q, e);
    total_cnt++;
    if ({v, e} !== 2'b10 || q !== 32'h0)
      $display("FAIL ready_reset_load got v=%b e=%b do=%h exp 1/0/0", v, e, q);
    else pass_cnt++;
  endtask

  initial begin
    resetN     = 1'b0;
    reqValid   = 1'b0;
    reqWrite   = 1'b0;
    address    = '0;
    dataIn     = '0;
    byteEnable = '0;
    test_reset();
    test_basic();
    test_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
